alu_seq: RTL and testbench

- Registered, parametrised successor to the combinational datapath ALU.
- Accepts an operation with START and executes it in one or more cycles. Adds a multi-bit shifter that shifts one bit per cycle and a shift-add multiplier.
- Results and the status flags C, B, Z and N are held in registers until the next accepted operation.
- Sits between the register file and the accumulator/flag logic of the CPU core. The controller uses BUSY/DONE to stall.

---
 rtl/alu_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with 1-bit/cycle shifter and shift-add multiplier.
// Ports:
//   CLK, nRST (async active-low)         clock / reset
//   START, IN_INSTR, IN_A, IN_B, Cin, Bin request and operands, sampled only in IDLE
//   BUSY, DONE                            handshake: BUSY while iterating, DONE one-cycle pulse
//   OUT, OUT_HI, Cout, Bout, ZERO, NEG    held result and status flags
// Optional feature: define ALU_DIV_EN to build opcode B as a restoring divider;
// otherwise opcode B behaves as pass-B.
//
// state | meaning
// IDLE  | waiting for START; single-cycle ops complete on the accepting edge
// EXEC  | iterating shift / multiply / divide, one step per cycle
// FIN   | DONE pulse, outputs valid, START ignored
module alu_seq #(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 4,
  parameter int SWIDTH = $clog2(DWIDTH)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  input  logic [IWIDTH-1:0] IN_INSTR,
  input  logic [DWIDTH-1:0] IN_A,
  input  logic [DWIDTH-1:0] IN_B,
  input  logic              Cin,
  input  logic              Bin,
  output logic              BUSY,
  output logic              DONE,
  output logic [DWIDTH-1:0] OUT,
  output logic [DWIDTH-1:0] OUT_HI,
  output logic              Cout,
  output logic              Bout,
  output logic              ZERO,
  output logic              NEG
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIN} state_t;

  localparam logic [IWIDTH-1:0] OP_NOT = IWIDTH'(0);
  localparam logic [IWIDTH-1:0] OP_XOR = IWIDTH'(1);
  localparam logic [IWIDTH-1:0] OP_OR  = IWIDTH'(2);
  localparam logic [IWIDTH-1:0] OP_AND = IWIDTH'(3);
  localparam logic [IWIDTH-1:0] OP_SUB = IWIDTH'(4);
  localparam logic [IWIDTH-1:0] OP_ADD = IWIDTH'(5);
  localparam logic [IWIDTH-1:0] OP_SHR = IWIDTH'(6);
  localparam logic [IWIDTH-1:0] OP_SHL = IWIDTH'(7);
  localparam logic [IWIDTH-1:0] OP_DEC = IWIDTH'(8);
  localparam logic [IWIDTH-1:0] OP_INC = IWIDTH'(9);
  localparam logic [IWIDTH-1:0] OP_MUL = IWIDTH'(10);
`ifdef ALU_DIV_EN
  localparam logic [IWIDTH-1:0] OP_DIV = IWIDTH'(11);
`endif

  localparam logic [SWIDTH-1:0] CNT_LAST = SWIDTH'(DWIDTH - 1);
  localparam logic [SWIDTH-1:0] CNT_ONE  = SWIDTH'(1);
  localparam logic [DWIDTH-1:0] ONE      = DWIDTH'(1);

  state_t            state_q, state_d;
  logic [SWIDTH-1:0] cnt_q, cnt_d;
  logic [IWIDTH-1:0] op_q, op_d;
  logic [DWIDTH-1:0] a_q, a_d;
  logic [DWIDTH-1:0] work_q, work_d;  // shift operand / product low / quotient
  logic [DWIDTH-1:0] hi_q, hi_d;      // product high / partial remainder
`ifdef ALU_DIV_EN
  logic [DWIDTH-1:0] b_q, b_d;
  logic [DWIDTH:0]   div_sh, div_sub;
`endif
  logic [DWIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic              c_q, c_d, bf_q, bf_d, z_q, z_d, n_q, n_d;

  logic [SWIDTH-1:0] amt;
  logic [DWIDTH:0]   sum_ext, diff_ext, mul_sum;
  logic [DWIDTH-1:0] sc_res;
  logic              sc_upd_c, sc_c, sc_upd_b, sc_b, exec_c;

  assign amt = IN_B[SWIDTH-1:0];

  // Result of every op that completes on the accepting edge.
  always_comb begin
    sum_ext  = {1'b0, IN_A} + {1'b0, IN_B} + {{DWIDTH{1'b0}}, Cin};
    diff_ext = {1'b0, IN_A} - {1'b0, IN_B} - {{DWIDTH{1'b0}}, Bin};
    sc_res   = IN_B;
    sc_upd_c = 1'b0;
    sc_c     = 1'b0;
    sc_upd_b = 1'b0;
    sc_b     = 1'b0;
    case (IN_INSTR)
      OP_NOT: sc_res = ~IN_A;
      OP_XOR: sc_res = IN_A ^ IN_B;
      OP_OR:  sc_res = IN_A | IN_B;
      OP_AND: sc_res = IN_A & IN_B;
      OP_SUB: begin sc_res = diff_ext[DWIDTH-1:0]; sc_upd_b = 1'b1; sc_b = diff_ext[DWIDTH]; end
      OP_ADD: begin sc_res = sum_ext[DWIDTH-1:0];  sc_upd_c = 1'b1; sc_c = sum_ext[DWIDTH]; end
      OP_SHR, OP_SHL: sc_res = IN_A;  // zero shift amount only
      OP_DEC: begin sc_res = IN_A - ONE; sc_upd_b = 1'b1; sc_b = (IN_A == '0); end
      OP_INC: begin sc_res = IN_A + ONE; sc_upd_c = 1'b1; sc_c = &IN_A; end
      default: sc_res = IN_B;
    endcase
  end

  // Multiplier step: add A if the current multiplier bit is set, then shift {carry,hi,lo} right.
  assign mul_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, a_q} : {(DWIDTH+1){1'b0}});
`ifdef ALU_DIV_EN
  // Divider step: bring next dividend bit into the remainder, subtract divisor if it fits.
  assign div_sh  = {hi_q, work_q[DWIDTH-1]};
  assign div_sub = div_sh - {1'b0, b_q};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    work_d   = work_q;
    hi_d     = hi_q;
`ifdef ALU_DIV_EN
    b_d      = b_q;
`endif
    out_d    = out_q;
    out_hi_d = out_hi_q;
    c_d      = c_q;
    bf_d     = bf_q;
    z_d      = z_q;
    n_d      = n_q;
    exec_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d = IN_INSTR;
          a_d  = IN_A;
          if ((IN_INSTR == OP_SHR || IN_INSTR == OP_SHL) && amt != '0) begin
            work_d  = IN_A;
            cnt_d   = amt - CNT_ONE;
            state_d = S_EXEC;
          end else if (IN_INSTR == OP_MUL) begin
            work_d  = IN_B;
            hi_d    = '0;
            cnt_d   = CNT_LAST;
            state_d = S_EXEC;
`ifdef ALU_DIV_EN
          end else if (IN_INSTR == OP_DIV && IN_B != '0) begin
            work_d  = IN_A;
            hi_d    = '0;
            b_d     = IN_B;
            cnt_d   = CNT_LAST;
            state_d = S_EXEC;
          end else if (IN_INSTR == OP_DIV) begin
            out_d    = '1;
            out_hi_d = IN_A;
            bf_d     = 1'b1;
            z_d      = 1'b0;
            n_d      = 1'b1;
            state_d  = S_FIN;
`endif
          end else begin
            out_d    = sc_res;
            out_hi_d = '0;
            z_d      = (sc_res == '0);
            n_d      = sc_res[DWIDTH-1];
            if (sc_upd_c) c_d = sc_c;
            if (sc_upd_b) bf_d = sc_b;
            state_d  = S_FIN;
          end
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_SHR: begin exec_c = work_q[0];        work_d = work_q >> 1; end
          OP_SHL: begin exec_c = work_q[DWIDTH-1]; work_d = work_q << 1; end
          OP_MUL: begin
            hi_d   = mul_sum[DWIDTH:1];
            work_d = {mul_sum[0], work_q[DWIDTH-1:1]};
          end
`ifdef ALU_DIV_EN
          OP_DIV: begin
            if (!div_sub[DWIDTH]) begin
              hi_d   = div_sub[DWIDTH-1:0];
              work_d = {work_q[DWIDTH-2:0], 1'b1};
            end else begin
              hi_d   = div_sh[DWIDTH-1:0];
              work_d = {work_q[DWIDTH-2:0], 1'b0};
            end
          end
`endif
          default: ;
        endcase
        if (cnt_q == '0) begin
          out_d = work_d;
          z_d   = (work_d == '0);
          n_d   = work_d[DWIDTH-1];
          if (op_q == OP_MUL) begin
            out_hi_d = hi_d;
            c_d      = (hi_d != '0);
            z_d      = ({hi_d, work_d} == '0);
            n_d      = hi_d[DWIDTH-1];
`ifdef ALU_DIV_EN
          end else if (op_q == OP_DIV) begin
            out_hi_d = hi_d;
            bf_d     = 1'b0;
`endif
          end else begin
            out_hi_d = '0;
            c_d      = exec_c;
          end
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      work_q   <= '0;
      hi_q     <= '0;
`ifdef ALU_DIV_EN
      b_q      <= '0;
`endif
      out_q    <= '0;
      out_hi_q <= '0;
      c_q      <= 1'b0;
      bf_q     <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      work_q   <= work_d;
      hi_q     <= hi_d;
`ifdef ALU_DIV_EN
      b_q      <= b_d;
`endif
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      c_q      <= c_d;
      bf_q     <= bf_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign BUSY   = (state_q == S_EXEC);
  assign DONE   = (state_q == S_FIN);
  assign OUT    = out_q;
  assign OUT_HI = out_hi_q;
  assign Cout   = c_q;
  assign Bout   = bf_q;
  assign ZERO   = z_q;
  assign NEG    = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (default parameters) against an arithmetic reference model.
module tb_alu_seq;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    instr = '0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic          cin = 1'b0, bin = 1'b0;
  logic          busy, done;
  logic [DW-1:0] out, out_hi;
  logic          cout, bout, zero, neg;

  int checks = 0;
  int errors = 0;
  logic e_c = 1'b0, e_b = 1'b0, e_z = 1'b0, e_n = 1'b0;

  alu_seq dut (
    .CLK(clk), .nRST(rst_n), .START(start), .IN_INSTR(instr), .IN_A(in_a), .IN_B(in_b),
    .Cin(cin), .Bin(bin), .BUSY(busy), .DONE(done), .OUT(out), .OUT_HI(out_hi),
    .Cout(cout), .Bout(bout), .ZERO(zero), .NEG(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: result, latency and flags from plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic ci, input logic bi,
                       output int lat, output logic [DW-1:0] eo, output logic [DW-1:0] eh);
    int t;
    int amt;
    amt = int'(b) % DW;
    lat = 1;
    eh  = '0;
    t   = 0;
    case (op)
      4'h0: eo = ~a;
      4'h1: eo = a ^ b;
      4'h2: eo = a | b;
      4'h3: eo = a & b;
      4'h4: begin t = int'(a) - int'(b) - int'(bi); eo = DW'(t); e_b = (t < 0); end
      4'h5: begin t = int'(a) + int'(b) + int'(ci); eo = DW'(t); e_c = (t > 255); end
      4'h6: begin
        eo = a >> amt;
        if (amt > 0) begin e_c = a[amt-1]; lat = amt + 1; end
      end
      4'h7: begin
        eo = a << amt;
        if (amt > 0) begin e_c = a[DW-amt]; lat = amt + 1; end
      end
      4'h8: begin eo = a - 8'd1; e_b = (a == 8'd0); end
      4'h9: begin eo = a + 8'd1; e_c = (a == 8'hFF); end
      4'hA: begin
        t = int'(a) * int'(b);
        eo = DW'(t);
        eh = DW'(t >> DW);
        e_c = (eh != 0);
        lat = DW + 1;
      end
`ifdef ALU_DIV_EN
      4'hB: begin
        if (b == 0) begin eo = 8'hFF; eh = a; e_b = 1'b1; end
        else begin eo = a / b; eh = a % b; e_b = 1'b0; lat = DW + 1; end
      end
`endif
      default: eo = b;
    endcase
    if (op == 4'hA) begin
      e_z = (eo == 0) && (eh == 0);
      e_n = eh[DW-1];
    end else begin
      e_z = (eo == 0);
      e_n = eo[DW-1];
    end
  endtask

  // Issue one op from a negedge; poke_busy>0 pulses START at that busy cycle,
  // poke_fin pulses START while DONE is high. Both must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic ci, input logic bi, input int poke_busy, input bit poke_fin);
    int lat, cycles, busy_cnt;
    bit seen;
    logic [DW-1:0] eo, eh;
    model(op, a, b, ci, bi, lat, eo, eh);
    instr = op; in_a = a; in_b = b; cin = ci; bin = bi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    instr = 4'h5; in_a = 8'($urandom); in_b = 8'($urandom); cin = 1'($urandom); bin = 1'($urandom);
    cycles = 0; busy_cnt = 0; seen = 0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1;
      else begin
        if (busy) busy_cnt++;
        start = (cycles == poke_busy);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", cycles, lat);
    check("busy_cycles", busy_cnt, lat - 1);
    check("out", 32'(out), 32'(eo));
    check("out_hi", 32'(out_hi), 32'(eh));
    check("cout", 32'(cout), 32'(e_c));
    check("bout", 32'(bout), 32'(e_b));
    check("zero", 32'(zero), 32'(e_z));
    check("neg", 32'(neg), 32'(e_n));
    instr = 4'h9;
    start = poke_fin;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("out_hold", 32'(out), 32'(eo));
  endtask

  initial begin
    int dsum;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_flags", {busy, done, cout, bout, zero, neg}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Make outputs nonzero, then abort a MUL with async reset.
    run_op(4'h0, 8'h00, 8'h00, 0, 0, 0, 0);
    run_op(4'h5, 8'hFF, 8'h01, 0, 0, 0, 0);
    instr = 4'hA; in_a = 8'hFF; in_b = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", {out_hi, out}, 32'd0);
    check("async_rst_flags", {busy, done, cout, bout, zero, neg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e_c = 1'b0; e_b = 1'b0;
    dsum = 0;
    repeat (12) begin @(negedge clk); dsum += int'(done); end
    check("no_done_after_rst", dsum, 0);

    // Directed cases.
    run_op(4'h5, 8'h10, 8'h20, 0, 0, 0, 0);
    run_op(4'h5, 8'hFF, 8'h01, 0, 0, 0, 0);
    run_op(4'h9, 8'hFF, 8'h00, 0, 0, 0, 0);
    run_op(4'h8, 8'h00, 8'h00, 0, 0, 0, 0);
    run_op(4'h7, 8'h81, 8'h03, 0, 0, 0, 0);
    run_op(4'h6, 8'h81, 8'h00, 0, 0, 0, 0);
    run_op(4'hA, 8'hFF, 8'hFF, 0, 0, 3, 0);
    run_op(4'h4, 8'h05, 8'h07, 0, 0, 0, 0);
    run_op(4'h3, 8'hF0, 8'h0F, 0, 0, 0, 1);
    run_op(4'h6, 8'h81, 8'h07, 0, 0, 2, 0);
    run_op(4'hA, 8'h00, 8'h37, 0, 0, 0, 0);
    run_op(4'hB, 8'd100, 8'd7, 0, 0, 0, 0);
    run_op(4'hB, 8'd3, 8'd0, 0, 0, 0, 0);
    run_op(4'hB, 8'd3, 8'd9, 0, 0, 0, 0);
    run_op(4'hF, 8'h12, 8'h80, 0, 0, 0, 0);

    // Randomised ops.
    for (int i = 0; i < 150; i++) begin
      logic [DW-1:0] rb;
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(0, 2));
      run_op(4'($urandom_range(0, 15)), 8'($urandom), rb, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 6)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
